// File: rtl/time_set_ctrl_if.sv
// Button and display bundle for the time-setting controller.
// master: debouncers, time base and consumers (testbench side).
// slave : the time_set_ctrl block.
interface time_set_ctrl_if;
    logic       mode_p;
    logic       sel_p;
    logic       up_p;
    logic       en1hz;
    logic       setmode;
    logic [1:0] digsel;
    logic       inchour;
    logic       incmin;
    logic       secclr;
    logic       count_en;
    logic       blink;

    modport master (
        output mode_p, sel_p, up_p, en1hz,
        input  setmode, digsel, inchour, incmin, secclr, count_en, blink
    );

    modport slave (
        input  mode_p, sel_p, up_p, en1hz,
        output setmode, digsel, inchour, incmin, secclr, count_en, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Set-mode controller for the digital clock.
// Turns debounced MODE/SELECT/UP presses into counter strobes, the counter
// run enable, and digit-select/blink controls for the display path.
// Optional feature: define AUTO_TIMEOUT_EN to build an idle timer that
// returns to NORMAL after TIMEOUT_SEC seconds without a button press.
//
// state    | meaning
// ---------+------------------------------------------------------------
// NORMAL   | clock running, no digits selected, buttons other than MODE ignored
// SET_HOUR | UP increments hours
// SET_MIN  | UP increments minutes
// SET_SEC  | UP clears seconds, time counters halted
module time_set_ctrl #(
    parameter int TIMEOUT_SEC = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    time_set_ctrl_if.slave     bus
);

    // State encoding equals the DIGSEL code so the digit select is the state.
    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        SET_SEC  = 2'b01,
        SET_MIN  = 2'b10,
        SET_HOUR = 2'b11
    } state_t;

    // Catch an out-of-range timeout at elaboration rather than in silicon.
    if (TIMEOUT_SEC < 1 || TIMEOUT_SEC > 63) begin : g_bad_timeout
        $error("time_set_ctrl: TIMEOUT_SEC must be in 1..63");
    end

    state_t state;
    state_t state_nxt;
    logic   setmode_q;
    logic   count_en_q;
    logic   blink_q;
    logic   blink_nxt;
    logic   inchour_q;
    logic   inchour_nxt;
    logic   incmin_q;
    logic   incmin_nxt;
    logic   secclr_q;
    logic   secclr_nxt;
    logic   timeout_hit;

`ifdef AUTO_TIMEOUT_EN
    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_SEC - 1);

    logic [5:0] idle_cnt;
    logic [5:0] idle_nxt;

    // Idle seconds counter: cleared by any press and while in NORMAL.
    always_comb begin
        idle_nxt    = idle_cnt;
        timeout_hit = 1'b0;
        if (state == NORMAL || bus.mode_p || bus.sel_p || bus.up_p) begin
            idle_nxt = 6'd0;
        end else if (bus.en1hz) begin
            if (idle_cnt == TIMEOUT_LAST) begin
                timeout_hit = 1'b1;
                idle_nxt    = 6'd0;
            end else begin
                idle_nxt = idle_cnt + 6'd1;
            end
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= 6'd0;
        end else begin
            idle_cnt <= idle_nxt;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, blink and strobe decision; MODE beats SELECT beats UP.
    always_comb begin
        state_nxt   = state;
        blink_nxt   = blink_q;
        inchour_nxt = 1'b0;
        incmin_nxt  = 1'b0;
        secclr_nxt  = 1'b0;

        if (bus.mode_p) begin
            state_nxt = (state == NORMAL) ? SET_HOUR : NORMAL;
            blink_nxt = 1'b1;
        end else if (state != NORMAL) begin
            if (bus.sel_p) begin
                case (state)
                    SET_HOUR: state_nxt = SET_MIN;
                    SET_MIN:  state_nxt = SET_SEC;
                    default:  state_nxt = SET_HOUR;
                endcase
                blink_nxt = 1'b1;
            end else if (bus.up_p) begin
                case (state)
                    SET_HOUR: inchour_nxt = 1'b1;
                    SET_MIN:  incmin_nxt  = 1'b1;
                    default:  secclr_nxt  = 1'b1;
                endcase
                blink_nxt = 1'b1;
            end else if (timeout_hit) begin
                state_nxt = NORMAL;
                blink_nxt = 1'b1;
            end else if (bus.en1hz) begin
                blink_nxt = ~blink_q;
            end
        end

        // Digits are always shown outside set mode.
        if (state_nxt == NORMAL) begin
            blink_nxt = 1'b1;
        end
    end

    // FSM state and every output registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            setmode_q  <= 1'b0;
            count_en_q <= 1'b1;
            blink_q    <= 1'b1;
            inchour_q  <= 1'b0;
            incmin_q   <= 1'b0;
            secclr_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            setmode_q  <= (state_nxt != NORMAL);
            count_en_q <= (state_nxt != SET_SEC);
            blink_q    <= blink_nxt;
            inchour_q  <= inchour_nxt;
            incmin_q   <= incmin_nxt;
            secclr_q   <= secclr_nxt;
        end
    end

    assign bus.setmode  = setmode_q;
    assign bus.digsel   = state;
    assign bus.count_en = count_en_q;
    assign bus.blink    = blink_q;
    assign bus.inchour  = inchour_q;
    assign bus.incmin   = incmin_q;
    assign bus.secclr   = secclr_q;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-setting controller for the digital clock. Consumes the single-cycle debounced press pulses from three button debouncers (MODE, SELECT, UP) and runs the clock's set-mode state machine. Drives increment/clear strobes to the hour/minute/second counters, the counter run enable, and digit-select/blink controls for the 7-segment display path. Sits between the debouncers and the time counters/display mux.

## Interface
Parameters:
- TIMEOUT_SEC, 30, idle seconds before automatic return to normal mode (1..63; used only with AUTO_TIMEOUT_EN)

Ports:
- CLK  in  1  system clock, 50 MHz
- RST  in  1  asynchronous, active-low reset
- MODE_P  in  1  debounced MODE press, one CLK cycle wide
- SEL_P  in  1  debounced SELECT press, one CLK cycle wide
- UP_P  in  1  debounced UP press, one CLK cycle wide
- EN1HZ  in  1  one-cycle pulse once per second from the time base
- SETMODE  out  1  1 while in any set state
- DIGSEL  out  2  digit group being set: 00 none, 01 sec, 10 min, 11 hour
- INCHOUR  out  1  one-cycle hour increment strobe
- INCMIN  out  1  one-cycle minute increment strobe
- SECCLR  out  1  one-cycle seconds clear strobe
- COUNT_EN  out  1  time counter run enable
- BLINK  out  1  1 = selected digits visible, 0 = blanked

## Operation
- States: NORMAL, SET_HOUR, SET_MIN, SET_SEC. Encoding is free; DIGSEL is derived from state.
- NORMAL: MODE_P -> SET_HOUR; SEL_P, UP_P ignored.
- Any set state: MODE_P -> NORMAL.
- SEL_P rotates SET_HOUR -> SET_MIN -> SET_SEC -> SET_HOUR.
- UP_P in SET_HOUR pulses INCHOUR, in SET_MIN pulses INCMIN, and in SET_SEC pulses SECCLR. State is unchanged.
- Simultaneous pulses have priority MODE_P > SEL_P > UP_P. The lower-priority pulses in that cycle are dropped; no queuing.
- Every high input cycle is one event; no edge detection is applied to the inputs.
- SETMODE = 1 in every state except NORMAL.
- COUNT_EN = 0 only in SET_SEC; otherwise 1.
- BLINK
  - Forced to 1 in NORMAL.
  - In set states it toggles on each EN1HZ.
  - Reloads to 1 on set-state entry, on a SEL_P state change, and on any UP_P. The reload wins over a same-cycle EN1HZ.
- Strobes never assert in NORMAL and never assert together.

## Timing
- All outputs are registered.
- Input pulse at edge N: state, DIGSEL, SETMODE, COUNT_EN and BLINK change at edge N+1, and any strobe is high for exactly the cycle after edge N+1.
- Latency is one cycle for every response.
- Back-to-back pulses on consecutive cycles are each processed.
- Reset value of all outputs: state NORMAL, SETMODE 0, DIGSEL 00, INCHOUR/INCMIN/SECCLR 0, COUNT_EN 1, BLINK 1.
- RST asserted mid-operation forces these values asynchronously, including truncating a strobe in flight.
- Release of RST is synchronised by the top level and is not handled here.

## Configuration
- With AUTO_TIMEOUT_EN defined, a 6-bit idle counter is compiled in:
  - It clears on any MODE_P/SEL_P/UP_P and whenever the state is NORMAL.
  - It increments on EN1HZ while in a set state.
  - When it equals TIMEOUT_SEC-1 and EN1HZ is high, the state returns to NORMAL at the next edge, with the outputs as on a MODE_P exit.
  - A button pulse in the same cycle as the timeout wins: the counter clears and the pulse is processed normally.
- Without AUTO_TIMEOUT_EN: no counter is built, and the set states persist until MODE_P.

## Test plan
- Reset released, no input -> SETMODE=0, DIGSEL=00, COUNT_EN=1, BLINK=1, no strobes for 1000 cycles.
- MODE_P, then SEL_P ×3 -> DIGSEL 11, 10, 01, 11; COUNT_EN=0 only while DIGSEL=01; MODE_P returns DIGSEL=00, COUNT_EN=1.
- In SET_MIN, UP_P ×2 separated by 5 cycles -> exactly two one-cycle INCMIN pulses, each one cycle after its UP_P; INCHOUR/SECCLR stay 0. In NORMAL, UP_P -> no strobe.
- MODE_P+SEL_P+UP_P in one cycle from SET_HOUR -> NORMAL, no strobe. SEL_P+UP_P from SET_HOUR -> SET_MIN, no INCHOUR.
- In SET_HOUR, 4 EN1HZ pulses -> BLINK 0,1,0,1. UP_P coincident with EN1HZ -> BLINK=1.
- AUTO_TIMEOUT_EN, TIMEOUT_SEC=3: enter SET_HOUR, 3 EN1HZ -> NORMAL one cycle after the 3rd. UP_P on the 3rd EN1HZ -> stays SET_HOUR and INCHOUR pulses. RST low mid-set -> immediate reset values.
